uart_rx_param: RTL and testbench

//  Parametrised UART receiver, next generation of the fixed 8N1 1 MBd deserializer.

---
 rtl/uart_rx_param.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF line synchroniser, mid-bit sampling FSM and a
// valid/ready output stage with frame, parity and overrun flags. Optional parity via UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLK_DIV    = 100,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_rxd,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_frame_err,
  output logic                 o_par_err,
  output logic                 o_overrun,
  output logic                 o_busy
);

  if (CLK_DIV < 4 || CLK_DIV > 4095 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1'b1) begin : g_bad_param
    $error("uart_rx_param: parameter out of range");
  end

  localparam logic [11:0] BIT_LAST  = 12'(CLK_DIV - 1);
  localparam logic [11:0] HALF_LAST = 12'(CLK_DIV / 2 - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_DELIVER
  } state_t;

  // Handshake: o_data/flags are stable while o_valid=1; a word transfers in any cycle
  // with o_valid && i_ready, and o_valid drops on the following edge unless a new word loads.

  logic [1:0]           rst_sync_q;
  logic                 rst_n;
  logic                 rxd_m_q;
  logic                 rxd_s_q;
  state_t               state_q;
  logic [11:0]          bcnt_q;
  logic [3:0]           bitidx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 ferr_acc_q;
  logic                 armed_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 ferr_q;
  logic                 ovr_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_m_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      rxd_m_q <= i_rxd;
      rxd_s_q <= rxd_m_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic parbit_q;
  logic perr_q;
  assign o_par_err = perr_q;
`else
  assign o_par_err = 1'b0;
`endif

  // armed_q blocks a restart until the line has been seen idle high, so a held-low
  // (break) line produces exactly one frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bcnt_q     <= '0;
      bitidx_q   <= '0;
      shift_q    <= '0;
      ferr_acc_q <= 1'b0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parbit_q   <= 1'b0;
      perr_q     <= 1'b0;
`endif
    end else begin
      if (valid_q && i_ready) begin
        valid_q <= 1'b0;
        ferr_q  <= 1'b0;
        ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_q  <= 1'b0;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (rxd_s_q) begin
            armed_q <= 1'b1;
          end else if (armed_q) begin
            armed_q <= 1'b0;
            bcnt_q  <= '0;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bcnt_q == HALF_LAST) begin
            bcnt_q   <= '0;
            bitidx_q <= '0;
            state_q  <= rxd_s_q ? S_IDLE : S_DATA;
          end else begin
            bcnt_q <= bcnt_q + 12'd1;
          end
        end
        S_DATA: begin
          if (bcnt_q == BIT_LAST) begin
            bcnt_q  <= '0;
            shift_q <= {rxd_s_q, shift_q[DATA_BITS-1:1]};
            if (bitidx_q == DATA_LAST) begin
              bitidx_q   <= '0;
              ferr_acc_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
              state_q    <= S_PARITY;
`else
              state_q    <= S_STOP;
`endif
            end else begin
              bitidx_q <= bitidx_q + 4'd1;
            end
          end else begin
            bcnt_q <= bcnt_q + 12'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (bcnt_q == BIT_LAST) begin
            bcnt_q   <= '0;
            parbit_q <= rxd_s_q;
            state_q  <= S_STOP;
          end else begin
            bcnt_q <= bcnt_q + 12'd1;
          end
        end
`endif
        S_STOP: begin
          if (bcnt_q == BIT_LAST) begin
            bcnt_q <= '0;
            if (!rxd_s_q) ferr_acc_q <= 1'b1;
            if (bitidx_q == STOP_LAST) begin
              state_q <= S_DELIVER;
            end else begin
              bitidx_q <= bitidx_q + 4'd1;
            end
          end else begin
            bcnt_q <= bcnt_q + 12'd1;
          end
        end
        S_DELIVER: begin
          state_q <= S_IDLE;
          if (!valid_q || i_ready) begin
            data_q  <= shift_q;
            ferr_q  <= ferr_acc_q;
            valid_q <= 1'b1;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= ((^shift_q) ^ parbit_q) != PARITY_ODD;
`endif
          end else begin
            ovr_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: serial frames are built from words at bit level and the
// received words are compared against a rule-based model of data, error and overrun flags.
module tb_uart_rx_param;
`ifdef UART_RX_PARITY_EN
  localparam int DB = 7;
  localparam int SB = 2;
  localparam int PEN = 1;
`else
  localparam int DB = 8;
  localparam int SB = 1;
  localparam int PEN = 0;
`endif
  localparam int DIV  = 100;
  localparam bit PODD = 1'b0;
  localparam int HALF = DIV / 2;
  localparam int W    = DB + 3;
  localparam int LAT  = 2 + HALF + (DB + PEN + SB) * DIV + 1;

  logic          clk;
  logic          i_rst_n;
  logic          i_rxd;
  logic [DB-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic          o_frame_err;
  logic          o_par_err;
  logic          o_overrun;
  logic          o_busy;

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(DB), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_rxd(i_rxd), .o_data(o_data), .o_valid(o_valid),
    .i_ready(i_ready), .o_frame_err(o_frame_err), .o_par_err(o_par_err),
    .o_overrun(o_overrun), .o_busy(o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;
  int t_fall = 0;

  // scoreboard: captured words {overrun, frame_err, par_err, data}
  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];
  int cap_cyc = 0;
  int valid_cnt = 0;
  int busy_cnt = 0;

  always @(negedge clk) begin
    if (o_valid) valid_cnt++;
    if (o_busy) busy_cnt++;
    if (o_valid && i_ready) begin
      got_q.push_back({o_overrun, o_frame_err, o_par_err, o_data});
      cap_cyc = cyc;
    end
  end

  function automatic logic good_par(input logic [8:0] word);
    logic [DB-1:0] d;
    d = word[DB-1:0];
    return 1'(($countones(d) + int'(PODD)) % 2);
  endfunction

  function automatic logic [W-1:0] model(input logic [8:0] word, input logic parbit,
                                         input logic stop_ok, input logic ovr);
    logic [DB-1:0] d;
    logic perr;
    d = word[DB-1:0];
    perr = (PEN == 1) && ((($countones(d) + int'(parbit)) % 2) != int'(PODD));
    return {ovr, ~stop_ok, perr, d};
  endfunction

  // driver tasks
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bit_time(input logic b);
    i_rxd = b;
    idle(DIV);
  endtask

  task automatic send_frame(input logic [8:0] word, input logic parbit, input logic stop_val);
    t_fall = cyc;
    bit_time(1'b0);
    for (int i = 0; i < DB; i++) bit_time(word[i]);
    if (PEN == 1) bit_time(parbit);
    for (int i = 0; i < SB; i++) bit_time(stop_val);
    i_rxd = 1'b1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    i_rxd   = 1'b1;
    i_ready = 1'b0;
    idle(3);
    checks++;
    if ({o_valid, o_data, o_frame_err, o_par_err, o_overrun, o_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required=0",
               {o_valid, o_data, o_frame_err, o_par_err, o_overrun, o_busy});
    end
    i_rst_n = 1'b1;
    idle(10);
  endtask

  task automatic test_basic;
    logic [W-1:0] item, exp_w;
    int v0, lat;
    i_ready = 1'b1;
    got_q.delete();
    v0 = valid_cnt;
    send_frame(9'h0A5, good_par(9'h0A5), 1'b1);
    idle(5);
    exp_w = model(9'h0A5, good_par(9'h0A5), 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL basic_count got=%0d required=1", got_q.size());
    end else begin
      item = got_q.pop_front();
      checks++;
      if (item !== exp_w) begin
        errors++;
        $display("FAIL basic_word got=%h required=%h", item, exp_w);
      end
      lat = cap_cyc - t_fall;
      checks++;
      if (lat < LAT - 2 || lat > LAT + 2) begin
        errors++;
        $display("FAIL basic_latency got=%0d required=%0d+-2", lat, LAT);
      end
    end
    checks++;
    if (valid_cnt - v0 != 1) begin
      errors++;
      $display("FAIL basic_valid_pulse got=%0d cycles required=1", valid_cnt - v0);
    end
  endtask

  task automatic test_glitch;
    int b0, v0;
    b0 = busy_cnt;
    v0 = valid_cnt;
    i_rxd = 1'b0;
    idle(30);
    i_rxd = 1'b1;
    idle(2 * DIV);
    checks++;
    if (busy_cnt - b0 < HALF - 3 || busy_cnt - b0 > HALF + 3) begin
      errors++;
      $display("FAIL glitch_busy got=%0d required=%0d+-3", busy_cnt - b0, HALF);
    end
    checks++;
    if (valid_cnt != v0) begin
      errors++;
      $display("FAIL glitch_valid got=%0d required=0", valid_cnt - v0);
    end
  endtask

  task automatic test_frame_err;
    logic [W-1:0] item;
    i_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    send_frame(9'h03C, good_par(9'h03C), 1'b0);
    exp_q.push_back(model(9'h03C, good_par(9'h03C), 1'b0, 1'b0));
    idle(DIV);
    send_frame(9'h011, good_par(9'h011), 1'b1);
    exp_q.push_back(model(9'h011, good_par(9'h011), 1'b1, 1'b0));
    idle(5);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL ferr_count got=%0d required=2", got_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        item = got_q.pop_front();
        checks++;
        if (item !== exp_q[i]) begin
          errors++;
          $display("FAIL ferr_word%0d got=%h required=%h", i, item, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_overrun;
    logic [W-1:0] item, exp_w;
    i_ready = 1'b0;
    got_q.delete();
    send_frame(9'h001, good_par(9'h001), 1'b1);
    send_frame(9'h002, good_par(9'h002), 1'b1);
    send_frame(9'h003, good_par(9'h003), 1'b1);
    idle(5);
    checks++;
    if ({o_valid, o_overrun, o_data} !== {1'b1, 1'b1, DB'(1)}) begin
      errors++;
      $display("FAIL overrun_hold got valid=%b ovr=%b data=%h required 1 1 01",
               o_valid, o_overrun, o_data);
    end
    i_ready = 1'b1;
    idle(1);
    i_ready = 1'b0;
    checks++;
    if ({o_valid, o_overrun, o_frame_err, o_par_err} !== 4'b0000) begin
      errors++;
      $display("FAIL overrun_clear got=%b required=0000",
               {o_valid, o_overrun, o_frame_err, o_par_err});
    end
    exp_w = model(9'h001, good_par(9'h001), 1'b1, 1'b1);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL overrun_count got=%0d required=1", got_q.size());
    end else begin
      item = got_q.pop_front();
      checks++;
      if (item !== exp_w) begin
        errors++;
        $display("FAIL overrun_word got=%h required=%h", item, exp_w);
      end
    end
  endtask

  task automatic test_break;
    logic [W-1:0] item, exp_w;
    i_ready = 1'b1;
    got_q.delete();
    i_rxd = 1'b0;
    idle(3 * (DB + PEN + SB + 1) * DIV);
    i_rxd = 1'b1;
    idle(DIV);
    send_frame(9'h05A, good_par(9'h05A), 1'b1);
    idle(5);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL break_count got=%0d required=2", got_q.size());
    end else begin
      item = got_q.pop_front();
      exp_w = model(9'h000, 1'b0, 1'b0, 1'b0);
      checks++;
      if (item !== exp_w) begin
        errors++;
        $display("FAIL break_word got=%h required=%h", item, exp_w);
      end
      item = got_q.pop_front();
      exp_w = model(9'h05A, good_par(9'h05A), 1'b1, 1'b0);
      checks++;
      if (item !== exp_w) begin
        errors++;
        $display("FAIL break_recover got=%h required=%h", item, exp_w);
      end
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    logic [W-1:0] item;
    i_ready = 1'b1;
    got_q.delete();
    send_frame(9'h055, 1'b1, 1'b1);
    idle(DIV);
    send_frame(9'h055, 1'b0, 1'b1);
    idle(5);
    checks++;
    if (got_q.size() != 2) begin
      errors++;
      $display("FAIL parity_count got=%0d required=2", got_q.size());
    end else begin
      item = got_q.pop_front();
      checks++;
      if (item !== {1'b0, 1'b0, 1'b1, 7'h55}) begin
        errors++;
        $display("FAIL parity_bad got=%h required=%h", item, {1'b0, 1'b0, 1'b1, 7'h55});
      end
      item = got_q.pop_front();
      checks++;
      if (item !== {1'b0, 1'b0, 1'b0, 7'h55}) begin
        errors++;
        $display("FAIL parity_good got=%h required=%h", item, {1'b0, 1'b0, 1'b0, 7'h55});
      end
    end
  endtask
`endif

  task automatic test_reset_mid;
    logic [W-1:0] item, exp_w;
    i_ready = 1'b0;
    got_q.delete();
    send_frame(9'h033, good_par(9'h033), 1'b1);
    idle(5);
    bit_time(1'b0);
    i_rxd = 1'b1;
    idle(3 * DIV + HALF);
    checks++;
    if ({o_valid, o_busy} !== 2'b11) begin
      errors++;
      $display("FAIL rstmid_pre got valid/busy=%b required=11", {o_valid, o_busy});
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_valid, o_data, o_frame_err, o_par_err, o_overrun, o_busy} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got=%b required=0",
               {o_valid, o_data, o_frame_err, o_par_err, o_overrun, o_busy});
    end
    idle(5);
    i_rst_n = 1'b1;
    idle(12 * DIV);
    i_ready = 1'b1;
    send_frame(9'h042, good_par(9'h042), 1'b1);
    idle(5);
    exp_w = model(9'h042, good_par(9'h042), 1'b1, 1'b0);
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count got=%0d required=1", got_q.size());
    end else begin
      item = got_q.pop_front();
      checks++;
      if (item !== exp_w) begin
        errors++;
        $display("FAIL rstmid_word got=%h required=%h", item, exp_w);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] item;
    logic [8:0] w;
    logic stop_ok, pb;
    int gap, n;
    i_ready = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 12; k++) begin
      w = 9'($urandom_range(0, 511));
      stop_ok = ($urandom_range(0, 3) != 0);
      pb = good_par(w);
      if (PEN == 1 && $urandom_range(0, 3) == 0) pb = ~pb;
      send_frame(w, pb, stop_ok);
      exp_q.push_back(model(w, pb, stop_ok, 1'b0));
      gap = stop_ok ? $urandom_range(0, DIV) : DIV + $urandom_range(0, DIV);
      if (gap > 0) idle(gap);
    end
    idle(5);
    n = exp_q.size();
    checks++;
    if (got_q.size() != n) begin
      errors++;
      $display("FAIL random_count got=%0d required=%0d", got_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        item = got_q.pop_front();
        checks++;
        if (item !== exp_q[i]) begin
          errors++;
          $display("FAIL random_word%0d got=%h required=%h", i, item, exp_q[i]);
        end
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_break();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
